// File: rtl/sdram_sim_pkg.sv
// Purpose : shared types and constants for the simulated SDRAM responder.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package sdram_sim_pkg;

    localparam int SDR_BEATS   = 4;
    localparam int SDR_WORD_W  = 16;
    localparam int SDR_Q_W     = 64;
    localparam int SDR_ADDR_W  = 27;
    localparam int SDR_BE_W    = SDR_Q_W / 8;
    localparam int SDR_WADDR_W = SDR_ADDR_W - 1;

    typedef enum logic [2:0] {
        IDLE,
        REFRESH,
        WAIT,
        BEAT,
        DONE
    } sdr_resp_state_t;

endpackage

// File: rtl/sdr_toggle_responder_if.sv
// Purpose : toggle req/ack request bus between arbiter (master) and responder (slave).
// Latency : n/a (wires only).
// Backpr. : a request is outstanding while sdr_req != sdr_ack; no new toggle until ack matches.
interface sdr_toggle_responder_if;
    import sdram_sim_pkg::*;

    logic [SDR_ADDR_W-1:0] sdr_addr;   // byte address
    logic [SDR_Q_W-1:0]    sdr_data;   // write data, beat k in [16k+15:16k]
    logic [SDR_BE_W-1:0]   sdr_be;     // byte enables, beat k in [2k+1:2k]
    logic                  sdr_rw;     // 1 = read, 0 = write
    logic                  sdr_req;    // request toggle
    logic                  sdr_ack;    // acknowledge toggle
    logic [SDR_Q_W-1:0]    sdr_q;      // read data

    modport master (
        output sdr_addr, sdr_data, sdr_be, sdr_rw, sdr_req,
        input  sdr_ack, sdr_q
    );

    modport slave (
        input  sdr_addr, sdr_data, sdr_be, sdr_rw, sdr_req,
        output sdr_ack, sdr_q
    );

endinterface

// File: rtl/sdr_refresh_timer.sv
// Purpose : free-running refresh interval counter raising a sticky refresh_due flag.
// Latency : refresh_due rises on the edge where the counter wraps; clears on the edge clr is high.
// Backpr. : none; refresh_due is held until the responder services it and pulses clr.
// Ports   : clk, reset_n (async active-low), clr (REFRESH exit), refresh_due (out).
module sdr_refresh_timer #(
    parameter int INTERVAL = 780   // 0 disables refresh entirely
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    output logic refresh_due
);

    logic [31:0] cnt_q, cnt_d;
    logic        due_q, due_d;
    logic        hit;

    always_comb begin
        cnt_d = cnt_q;
        due_d = due_q;
        hit   = 1'b0;
        if (INTERVAL != 0) begin
            hit   = (cnt_q == 32'(INTERVAL - 1));
            cnt_d = hit ? 32'd0 : cnt_q + 32'd1;
        end
        if (clr) begin
            due_d = 1'b0;
        end
        // A wrap coinciding with a clear starts a new interval, so set wins.
        if (hit) begin
            due_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 32'd0;
            due_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            due_q <= due_d;
        end
    end

    assign refresh_due = due_q;

endmodule

// File: rtl/sdr_toggle_responder.sv
// Purpose : memory-side responder for the toggle req/ack SDRAM protocol; one 64-bit access as four x16 beats.
// Latency : sample edge to ack edge = CAS_LATENCY+6 (read) / CAS_LATENCY+5 (write), plus any refresh ahead of it.
// Backpr. : one request in flight; extra toggles before ack are not seen until DONE re-exposes the mismatch.
// Ports   : clk, reset_n (async active-low); bus (slave modport: sdr_addr/data/be/rw/req in, sdr_ack/sdr_q out);
//           mem_addr/mem_wdata/mem_be/mem_we/mem_rd out, mem_rdata in (valid 1 cycle after mem_rd); busy out.
// Option  : define SDR_RESP_JITTER_EN to add 0..7 LFSR-chosen extra WAIT cycles per request.
module sdr_toggle_responder
    import sdram_sim_pkg::*;
#(
    parameter int          CAS_LATENCY      = 2,
    parameter int          REFRESH_INTERVAL = 780,
    parameter int          REFRESH_CYCLES   = 8,
    parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    sdr_toggle_responder_if.slave   bus,
    output logic [SDR_WADDR_W-1:0]  mem_addr,
    output logic [SDR_WORD_W-1:0]   mem_wdata,
    output logic [1:0]              mem_be,
    output logic                    mem_we,
    output logic                    mem_rd,
    input  logic [SDR_WORD_W-1:0]   mem_rdata,
    output logic                    busy
);

    sdr_resp_state_t        state_q, state_d;
    logic [2:0]             beat_q, beat_d;       // 0..3 strobe beats, 4 = read tail capture
    logic [4:0]             wait_q, wait_d;
    logic [15:0]            rcyc_q, rcyc_d;
    logic [SDR_WADDR_W-1:0] addr_q, addr_d;
    logic [SDR_Q_W-1:0]     data_q, data_d;
    logic [SDR_BE_W-1:0]    be_q, be_d;
    logic                   rw_q, rw_d;
    logic                   req_q, req_d;
    logic                   ack_q, ack_d;
    logic [SDR_Q_W-1:0]     q_q, q_d;
    logic [47:0]            shadow_q, shadow_d;   // beats 0..2 held until beat 3 lands
    logic                   rd_pend_q;
    logic                   refresh_due, refresh_clr;
    logic [4:0]             wait_total;
    logic                   strobe;
    logic [1:0]             bsel, cap_idx, beat_be;
    logic                   unused_addr_lsb;

    assign unused_addr_lsb = bus.sdr_addr[0];

`ifdef SDR_RESP_JITTER_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) lfsr_q <= LFSR_SEED;
        else          lfsr_q <= lfsr_d;
    end

    assign wait_total = 5'(CAS_LATENCY) + {2'b00, lfsr_q[2:0]};
`else
    localparam logic [15:0] UNUSED_SEED = LFSR_SEED;
    assign wait_total = 5'(CAS_LATENCY);
`endif

    sdr_refresh_timer #(
        .INTERVAL    (REFRESH_INTERVAL)
    ) u_refresh (
        .clk         (clk),
        .reset_n     (reset_n),
        .clr         (refresh_clr),
        .refresh_due (refresh_due)
    );

    // Memory strobes are decoded straight from state so reset clears them asynchronously.
    assign strobe    = (state_q == BEAT) && !beat_q[2];
    assign bsel      = beat_q[1:0];
    assign beat_be   = be_q[{bsel, 1'b0} +: 2];
    assign mem_rd    = strobe && rw_q;
    assign mem_we    = strobe && !rw_q && (beat_be != 2'b00);
    assign mem_addr  = strobe ? addr_q + SDR_WADDR_W'(bsel) : '0;
    assign mem_wdata = mem_we ? data_q[{bsel, 4'b0000} +: SDR_WORD_W] : '0;
    assign mem_be    = mem_we ? beat_be : 2'b00;
    // Read data returned now belongs to the beat issued one cycle earlier.
    assign cap_idx   = beat_q[1:0] - 2'd1;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        wait_d      = wait_q;
        rcyc_d      = rcyc_q;
        addr_d      = addr_q;
        data_d      = data_q;
        be_d        = be_q;
        rw_d        = rw_q;
        req_d       = req_q;
        ack_d       = ack_q;
        q_d         = q_q;
        shadow_d    = shadow_q;
        refresh_clr = 1'b0;

        // sdr_q is only updated as a whole when the last read beat arrives.
        if (rd_pend_q) begin
            case (cap_idx)
                2'd0:    shadow_d[15:0]  = mem_rdata;
                2'd1:    shadow_d[31:16] = mem_rdata;
                2'd2:    shadow_d[47:32] = mem_rdata;
                default: q_d             = {mem_rdata, shadow_q};
            endcase
        end

        case (state_q)
            IDLE: begin
                if (refresh_due) begin
                    state_d = REFRESH;
                    rcyc_d  = 16'(REFRESH_CYCLES - 1);
                end else if (bus.sdr_req != ack_q) begin
                    addr_d = bus.sdr_addr[SDR_ADDR_W-1:1];
                    data_d = bus.sdr_data;
                    be_d   = bus.sdr_be;
                    rw_d   = bus.sdr_rw;
                    req_d  = bus.sdr_req;
                    beat_d = 3'd0;
                    if (wait_total == 5'd0) begin
                        state_d = BEAT;
                    end else begin
                        state_d = WAIT;
                        wait_d  = wait_total - 5'd1;
                    end
                end
            end
            REFRESH: begin
                if (rcyc_q == 16'd0) begin
                    state_d     = IDLE;
                    refresh_clr = 1'b1;
                end else begin
                    rcyc_d = rcyc_q - 16'd1;
                end
            end
            WAIT: begin
                if (wait_q == 5'd0) begin
                    state_d = BEAT;
                    beat_d  = 3'd0;
                end else begin
                    wait_d = wait_q - 5'd1;
                end
            end
            BEAT: begin
                // Reads spend one extra cycle so the last returned word is captured.
                if (beat_q == (rw_q ? 3'd4 : 3'd3)) begin
                    state_d = DONE;
                end else begin
                    beat_d = beat_q + 3'd1;
                end
            end
            DONE: begin
                ack_d   = req_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            beat_q    <= 3'd0;
            wait_q    <= 5'd0;
            rcyc_q    <= 16'd0;
            addr_q    <= '0;
            data_q    <= '0;
            be_q      <= '0;
            rw_q      <= 1'b0;
            req_q     <= 1'b0;
            ack_q     <= 1'b0;
            q_q       <= '0;
            shadow_q  <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            wait_q    <= wait_d;
            rcyc_q    <= rcyc_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            be_q      <= be_d;
            rw_q      <= rw_d;
            req_q     <= req_d;
            ack_q     <= ack_d;
            q_q       <= q_d;
            shadow_q  <= shadow_d;
            rd_pend_q <= mem_rd;
        end
    end

    assign bus.sdr_ack = ack_q;
    assign bus.sdr_q   = q_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_sdr_toggle_responder.sv
// Purpose : scoreboard bench for sdr_toggle_responder; one instance without refresh, one with a short refresh interval.
// Latency : expected ack cycle per request = issue cycle + 1 + (CAS+6 read / CAS+5 write).
// Backpr. : the initiator never toggles again before ack; the assertion flags any violation.
module tb_sdr_toggle_responder;

    logic        clk;
    logic        reset_n;
    int          cyc;
    int          checks;
    int          errors;

    // Main instance: CAS 2, refresh off.
    sdr_toggle_responder_if u_if ();
    logic [25:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_be;
    logic        mem_we, mem_rd, busy;
    logic [15:0] mem_rdata;
    bit   [15:0] mem0 [bit [25:0]];

    // Refresh instance: CAS 2, refresh every 20 cycles for 8 cycles.
    sdr_toggle_responder_if r_if ();
    logic [25:0] mem_addr_r;
    logic [15:0] mem_wdata_r;
    logic [1:0]  mem_be_r;
    logic        mem_we_r, mem_rd_r, busy_r;
    logic [15:0] mem_rdata_r;

    sdr_toggle_responder #(
        .CAS_LATENCY(2), .REFRESH_INTERVAL(0), .REFRESH_CYCLES(8), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(u_if.slave),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_we(mem_we), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .busy(busy)
    );

    sdr_toggle_responder #(
        .CAS_LATENCY(2), .REFRESH_INTERVAL(20), .REFRESH_CYCLES(8), .LFSR_SEED(16'hACE1)
    ) dut_r (
        .clk(clk), .reset_n(reset_n), .bus(r_if.slave),
        .mem_addr(mem_addr_r), .mem_wdata(mem_wdata_r), .mem_be(mem_be_r),
        .mem_we(mem_we_r), .mem_rd(mem_rd_r), .mem_rdata(mem_rdata_r), .busy(busy_r)
    );

    typedef struct { int cyc; logic [63:0] q; } ack_exp_t;
    typedef struct { bit rd; logic [25:0] addr; logic [15:0] wdata; logic [1:0] be; } strb_exp_t;
    ack_exp_t  exp_ack  [$];
    strb_exp_t exp_strb [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // x16 backing memory, read data one cycle after mem_rd.
    always @(posedge clk) begin
        bit [15:0] w;
        if (mem_rd) mem_rdata <= mem0[mem_addr];
        if (mem_we) begin
            w = mem0[mem_addr];
            if (mem_be[0]) w[7:0]  = mem_wdata[7:0];
            if (mem_be[1]) w[15:8] = mem_wdata[15:8];
            mem0[mem_addr] = w;
        end
    end

    // Initiator must not toggle req again before the previous toggle is acknowledged.
    a_no_early_toggle: assert property (@(posedge clk) disable iff (!reset_n)
        $changed(u_if.sdr_req) |-> ($past(u_if.sdr_req) == u_if.sdr_ack))
        else $error("protocol violation: req toggled before ack");

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one request just after a posedge and queue what the monitors should see.
    task automatic issue(input logic [26:0] addr, input logic [63:0] data, input logic [7:0] be,
                         input bit rw, input logic [63:0] q_exp);
        ack_exp_t  a;
        strb_exp_t s;
        u_if.sdr_addr = addr;
        u_if.sdr_data = data;
        u_if.sdr_be   = be;
        u_if.sdr_rw   = rw;
        u_if.sdr_req  = ~u_if.sdr_req;
        a.cyc = cyc + 1 + (rw ? 8 : 7);
        a.q   = q_exp;
        exp_ack.push_back(a);
        for (int k = 0; k < 4; k++) begin
            s.rd    = rw;
            s.addr  = addr[26:1] + 26'(k);
            s.wdata = rw ? 16'h0 : data[16*k +: 16];
            s.be    = rw ? 2'b00 : be[2*k +: 2];
            if (rw || be[2*k +: 2] != 2'b00) exp_strb.push_back(s);
        end
    endtask

    task automatic wait_ack();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge clk);
            #1;
            if (u_if.sdr_ack == u_if.sdr_req) done = 1'b1;
        end
        chk("ack_timeout", {63'd0, done}, 64'd1);
    endtask

    // Ack scoreboard monitor.
    initial begin : ack_mon
        logic     prev;
        ack_exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev = 1'b0;
            end else if (u_if.sdr_ack != prev) begin
                prev = u_if.sdr_ack;
                if (exp_ack.size() == 0) begin
                    chk("unexpected_ack", 64'(cyc), 64'hFFFF_FFFF);
                end else begin
                    e = exp_ack.pop_front();
                    chk("ack_cycle", 64'(cyc), 64'(e.cyc));
                    chk("sdr_q", u_if.sdr_q, e.q);
                end
            end
        end
    end

    // Memory strobe scoreboard monitor.
    initial begin : strb_mon
        strb_exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && (mem_we || mem_rd)) begin
                if (exp_strb.size() == 0) begin
                    chk("unexpected_strobe", {37'd0, mem_addr}, 64'hFFFF_FFFF);
                end else begin
                    e = exp_strb.pop_front();
                    chk("strb_rd", {63'd0, mem_rd}, {63'd0, e.rd});
                    chk("strb_addr", {38'd0, mem_addr}, {38'd0, e.addr});
                    chk("strb_wdata", {48'd0, mem_wdata}, {48'd0, e.wdata});
                    chk("strb_be", {62'd0, mem_be}, {62'd0, e.be});
                end
            end
        end
    end

    initial begin
        int  t;
        bit  found;
        cyc = 0; checks = 0; errors = 0;
        reset_n = 1'b0;
        mem_rdata = 16'h0; mem_rdata_r = 16'h0;
        u_if.sdr_addr = '0; u_if.sdr_data = '0; u_if.sdr_be = '0; u_if.sdr_rw = 1'b0; u_if.sdr_req = 1'b0;
        r_if.sdr_addr = '0; r_if.sdr_data = '0; r_if.sdr_be = '0; r_if.sdr_rw = 1'b0; r_if.sdr_req = 1'b0;
        mem0[26'h100] = 16'h1111; mem0[26'h101] = 16'h2222;
        mem0[26'h102] = 16'h3333; mem0[26'h103] = 16'h4444;
        mem0[26'h3FFFFFE] = 16'h5E01; mem0[26'h3FFFFFF] = 16'h5E02;
        mem0[26'h0000000] = 16'h5E03; mem0[26'h0000001] = 16'h5E04;

        repeat (3) @(negedge clk);
        chk("rst_ack",  {63'd0, u_if.sdr_ack}, 64'd0);
        chk("rst_q",    u_if.sdr_q, 64'd0);
        chk("rst_strb", {62'd0, mem_we, mem_rd}, 64'd0);
        chk("rst_addr", {38'd0, mem_addr}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Read word 0x100..0x103.
        issue(27'h200, 64'h0, 8'h00, 1'b1, 64'h4444_3333_2222_1111);
        wait_ack();
        // Write beats 0 and 3 only; sdr_q holds.
        issue(27'h200, 64'hDDDD_CCCC_BBBB_AAAA, 8'b1100_0011, 1'b0, 64'h4444_3333_2222_1111);
        wait_ack();
        chk("mem_w100", {48'd0, mem0[26'h100]}, 64'h0000_0000_0000_AAAA);
        chk("mem_w101", {48'd0, mem0[26'h101]}, 64'h0000_0000_0000_2222);
        chk("mem_w102", {48'd0, mem0[26'h102]}, 64'h0000_0000_0000_3333);
        chk("mem_w103", {48'd0, mem0[26'h103]}, 64'h0000_0000_0000_DDDD);
        // Single-byte enables: high byte of word 0x100, low byte of word 0x101.
        issue(27'h200, 64'h0000_0000_1234_5678, 8'b0000_0110, 1'b0, 64'h4444_3333_2222_1111);
        wait_ack();
        issue(27'h200, 64'h0, 8'h00, 1'b1, 64'hDDDD_3333_2234_56AA);
        wait_ack();
        // Address wrap past the top of the word space.
        issue(27'h7FFFFFC, 64'h0, 8'h00, 1'b1, 64'h5E04_5E03_5E02_5E01);
        wait_ack();

        // Back-to-back: toggle right after ack, busy low exactly one cycle.
        issue(27'h200, 64'h0, 8'h00, 1'b1, 64'hDDDD_3333_2234_56AA);
        wait_ack();
        issue(27'h010, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0, 64'hDDDD_3333_2234_56AA);
        @(negedge clk);
        chk("b2b_busy_gap", {63'd0, busy}, 64'd0);
        @(negedge clk);
        chk("b2b_busy_back", {63'd0, busy}, 64'd1);
        wait_ack();

        // Reset during beat 1 of a write: beat 0 stays written, beat 1 never lands.
        issue(27'h400, 64'h9999_8888_7777_6666, 8'hFF, 1'b0, 64'h0);
        repeat (4) @(posedge clk);
        #2;
        chk("beat1_we",   {63'd0, mem_we}, 64'd1);
        chk("beat1_addr", {38'd0, mem_addr}, 64'h201);
        reset_n = 1'b0;
        u_if.sdr_req = 1'b0;
        #1;
        chk("arst_ack",   {63'd0, u_if.sdr_ack}, 64'd0);
        chk("arst_q",     u_if.sdr_q, 64'd0);
        chk("arst_strb",  {62'd0, mem_we, mem_rd}, 64'd0);
        chk("arst_addr",  {38'd0, mem_addr}, 64'd0);
        chk("arst_wdata", {44'd0, mem_wdata, mem_be}, 64'd0);
        chk("arst_busy",  {63'd0, busy}, 64'd0);
        exp_ack.delete();
        exp_strb.delete();
        chk("partial_w200", {48'd0, mem0[26'h200]}, 64'h6666);
        chk("partial_w201", {48'd0, mem0[26'h201]}, 64'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        issue(27'h200, 64'h0, 8'h00, 1'b1, 64'hDDDD_3333_2234_56AA);
        wait_ack();

        // Refresh instance: find the start of an idle refresh (due rose one edge earlier),
        // then toggle a write so it is pending in the cycle the next due rises.
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (!busy_r) found = 1'b1;
        end
        chk("ref_sync_idle", {63'd0, found}, 64'd1);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (busy_r) found = 1'b1;
        end
        chk("ref_sync_start", {63'd0, found}, 64'd1);
        repeat (19) @(posedge clk);
        #1;
        r_if.sdr_addr = 27'h200; r_if.sdr_data = 64'h1; r_if.sdr_be = 8'hFF; r_if.sdr_rw = 1'b0;
        r_if.sdr_req = ~r_if.sdr_req;
        t = cyc;
        @(negedge clk);
        chk("ref_idle_first", {63'd0, busy_r}, 64'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("ref_busy", {63'd0, busy_r}, 64'd1);
            chk("ref_no_strobe", {62'd0, mem_we_r, mem_rd_r}, 64'd0);
        end
        @(negedge clk);
        chk("ref_idle_after", {63'd0, busy_r}, 64'd0);
        // 8 REFRESH cycles + 1 IDLE cycle, then sampling edge + CAS+5 for the write.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #1;
            if (r_if.sdr_ack == r_if.sdr_req) found = 1'b1;
        end
        chk("ref_ack_seen", {63'd0, found}, 64'd1);
        chk("ref_ack_cycle", 64'(cyc), 64'(t + 17));

        repeat (5) @(posedge clk);
        chk("ack_queue_empty", 64'(exp_ack.size()), 64'd0);
        chk("strb_queue_empty", 64'(exp_strb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
